// File: rtl/mem_latency_responder_if.sv
// mem_latency_responder_if: CPU data-memory request/response bundle between an initiator and the responder.
//   rd, wr         request strobes from the initiator, valid with addr (and wr_data for writes)
//   addr           byte address of the request
//   wr_data        write data
//   mem_ready      responder idle; a request is accepted on an edge where it is high
//   rd_data        registered read data, meaningful while rd_data_valid
//   rd_data_valid  one-cycle read-data pulse
//   mem_err        one-cycle error pulse (present only when MEM_RESP_ERR_EN is defined)
interface mem_latency_responder_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        mem_ready;
    logic [31:0] rd_data;
    logic        rd_data_valid;
`ifdef MEM_RESP_ERR_EN
    logic        mem_err;
    modport master (output rd, wr, addr, wr_data, input mem_ready, rd_data, rd_data_valid, mem_err);
    modport slave (input rd, wr, addr, wr_data, output mem_ready, rd_data, rd_data_valid, mem_err);
`else
    modport master (output rd, wr, addr, wr_data, input mem_ready, rd_data, rd_data_valid);
    modport slave (input rd, wr, addr, wr_data, output mem_ready, rd_data, rd_data_valid);
`endif
endinterface

// File: rtl/mem_latency_responder.sv
// mem_latency_responder: fixed-latency word memory answering CPU load/store requests, one request in flight.
module mem_latency_responder #(
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = ""
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_latency_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          op_rd, op_wr, err;
  logic [AW-1:0] idx;
  logic [31:0]   data_q, rd_q;
  logic [31:0]   mem [DEPTH];
  logic          accept, commit, req_err;
`ifdef MEM_RESP_ERR_EN
  assign req_err = (bus.rd && bus.wr) || (bus.addr[1:0] != 2'b00) || (|bus.addr[31:AW+2]);
  assign bus.mem_err = (state == DONE) && err;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};
  assign req_err = 1'b0;
`endif
  assign accept            = (state == IDLE) && (bus.rd || bus.wr);
  assign commit            = (state == WAIT) && (cnt == '0);
  assign bus.mem_ready     = state == IDLE;
  assign bus.rd_data_valid = (state == DONE) && op_rd;
  assign bus.rd_data       = rd_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE ? (accept ? WAIT : IDLE) :
               state == WAIT ? (commit ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      op_rd  <= 1'b0;
      op_wr  <= 1'b0;
      err    <= 1'b0;
      idx    <= '0;
      data_q <= '0;
      rd_q   <= '0;
    end else begin
      if (accept) begin
        cnt    <= CW'(LATENCY - 1);
        op_rd  <= bus.rd && !bus.wr;
        op_wr  <= bus.wr;
        err    <= req_err;
        idx    <= bus.addr[AW+1:2];
        data_q <= bus.wr_data;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit && op_rd) rd_q <= err ? 32'hDEAD_BEEF : mem[idx];
    end
  end
  always_ff @(posedge clk) begin
    if (commit && op_wr && !err) mem[idx] <= data_q;
  end
endmodule

// File: tb/tb_mem_latency_responder.sv
// tb_mem_latency_responder: randomized self-checking bench with a word-level reference model.
module tb_mem_latency_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 4;
`ifdef MEM_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_latency_responder_if bus();
    mem_latency_responder_if bus1();

    mem_latency_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .INIT_FILE("")) dut (.clk(clk), .rst(rst), .bus(bus));
    mem_latency_responder #(.DEPTH(64), .LATENCY(1), .INIT_FILE("")) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [31:0] model [int];
    logic [31:0] last_rd = 32'h0;
    bit          e_v, e_e;
    logic [31:0] e_d;

    bit          o_timeout, o_low;
    int          o_vcnt, o_vk, o_ecnt;
    logic [31:0] o_data, o_hold;
    logic        o_ready_end;

    always @(posedge clk) begin
        #1;
        if (bus.rd_data_valid === 1'b1) pulses++;
    end

    function automatic logic err_of();
`ifdef MEM_RESP_ERR_EN
        return bus.mem_err;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit is_err(bit r, bit w, logic [31:0] a);
        return ERR_EN && ((r && w) || a[1:0] != 2'b00 || a >= 32'(DEPTH * 4));
    endfunction

    function automatic logic [10:0] exp_sig(bit v, bit e);
        return {1'b0, 1'b1, 1'b1, v ? 2'd1 : 2'd0, v ? 4'(LAT) : 4'hF, e ? 2'd1 : 2'd0};
    endfunction

    function automatic logic [10:0] obs_sig();
        return {o_timeout, o_low, o_ready_end, 2'(o_vcnt), 4'(o_vk), 2'(o_ecnt)};
    endfunction

    task automatic wait_ready(output bit to);
        int n = 0;
        @(negedge clk);
        while (bus.mem_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        to = (n >= 50);
    endtask

    // Issue one request, then observe the LAT+1 cycles that follow its acceptance edge.
    task automatic run_xact(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        o_low = 1'b1; o_vcnt = 0; o_vk = -1; o_ecnt = 0; o_data = 'x; o_ready_end = 1'b0;
        wait_ready(o_timeout);
        if (o_timeout) return;
        bus.rd = r; bus.wr = w; bus.addr = a; bus.wr_data = d;
        @(posedge clk);
        #1;
        bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = $urandom; bus.wr_data = $urandom;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk);
            #1;
            if (k <= LAT && bus.mem_ready !== 1'b0) o_low = 1'b0;
            if (bus.rd_data_valid === 1'b1) begin
                o_vcnt++;
                o_vk = k;
                o_data = bus.rd_data;
            end
            if (err_of() === 1'b1) o_ecnt++;
            if (k == LAT + 1) begin
                o_ready_end = bus.mem_ready;
                o_hold = bus.rd_data;
            end
        end
    endtask

    // Reference model: word store indexed modulo DEPTH, error requests never touch it.
    task automatic model_apply(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        e_e = is_err(r, w, a);
        e_v = r && !w;
        if (w && !e_e) model[widx(a)] = d;
        e_d = e_e ? 32'hDEAD_BEEF : (model.exists(widx(a)) ? model[widx(a)] : 32'hx);
        if (e_v) last_rd = e_d;
    endtask

    task automatic xact(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        model_apply(r, w, a, d);
        run_xact(r, w, a, d);
    endtask

    task automatic test_reset;
        bus.rd = 0; bus.wr = 0; bus.addr = 0; bus.wr_data = 0;
        bus1.rd = 0; bus1.wr = 0; bus1.addr = 0; bus1.wr_data = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.mem_ready, bus.rd_data_valid, err_of(), bus.rd_data} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b valid=%b err=%b data=%h want 1 0 0 00000000",
                     bus.mem_ready, bus.rd_data_valid, err_of(), bus.rd_data);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.mem_ready, bus.rd_data_valid, bus1.mem_ready} !== 3'b101) begin
            errors++;
            $display("FAIL reset_release: got ready=%b valid=%b ready1=%b want 1 0 1",
                     bus.mem_ready, bus.rd_data_valid, bus1.mem_ready);
        end
    endtask

    task automatic test_basic;
        xact(0, 1, 32'h10, 32'hCAFE_0001);
        checks++;
        if (obs_sig() !== exp_sig(e_v, e_e)) begin
            errors++;
            $display("FAIL basic_wr_timing: got %h want %h", obs_sig(), exp_sig(e_v, e_e));
        end
        xact(1, 0, 32'h10, 32'h0);
        checks++;
        if (obs_sig() !== exp_sig(e_v, e_e)) begin
            errors++;
            $display("FAIL basic_rd_timing: got %h want %h", obs_sig(), exp_sig(e_v, e_e));
        end
        checks++;
        if (o_data !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL basic_rd_data: got %h want cafe0001", o_data);
        end
    endtask

    task automatic test_wrap;
        xact(0, 1, 32'h4, 32'h1234_5678);
        xact(1, 0, 32'h1004, 32'h0);
        checks++;
        if (obs_sig() !== exp_sig(e_v, e_e)) begin
            errors++;
            $display("FAIL wrap_timing: got %h want %h", obs_sig(), exp_sig(e_v, e_e));
        end
        checks++;
        if (o_data !== e_d) begin
            errors++;
            $display("FAIL wrap_data: got %h want %h", o_data, e_d);
        end
    endtask

    task automatic test_ignored;
        int p0;
        bit to;
        p0 = pulses;
        xact(1, 0, 32'h10, 32'h0);
        wait_ready(to);
        model_apply(0, 1, 32'h14, 32'hA5A5_0014);
        bus.wr = 1'b1; bus.addr = 32'h14; bus.wr_data = 32'hA5A5_0014;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.rd = 1'b1; bus.addr = 32'h10;
        @(posedge clk);
        #1;
        bus.rd = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #2;
        checks++;
        if (to || pulses - p0 !== 1) begin
            errors++;
            $display("FAIL ignored_pulses: got %0d pulses timeout=%0b want 1", pulses - p0, to);
        end
        xact(1, 0, 32'h14, 32'h0);
        checks++;
        if (o_data !== e_d || o_vcnt !== 1) begin
            errors++;
            $display("FAIL ignored_wr_commit: got %h (%0d pulses) want %h", o_data, o_vcnt, e_d);
        end
    endtask

    task automatic test_reset_abort;
        bit to;
        xact(0, 1, 32'h20, 32'h0);
        wait_ready(to);
        bus.wr = 1'b1; bus.addr = 32'h20; bus.wr_data = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (to || {bus.mem_ready, bus.rd_data_valid, bus.rd_data} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL abort_async: got ready=%b valid=%b data=%h want 1 0 00000000",
                     bus.mem_ready, bus.rd_data_valid, bus.rd_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_rd = 32'h0;
        xact(1, 0, 32'h20, 32'h0);
        checks++;
        if (o_data !== 32'h0 || o_vcnt !== 1) begin
            errors++;
            $display("FAIL abort_no_commit: got %h (%0d pulses) want 00000000", o_data, o_vcnt);
        end
    endtask

    task automatic test_rd_wr_both;
        xact(0, 1, 32'h30, 32'h11);
        xact(1, 1, 32'h30, 32'h55);
        checks++;
        if (obs_sig() !== exp_sig(1'b0, ERR_EN)) begin
            errors++;
            $display("FAIL rdwr_timing: got %h want %h", obs_sig(), exp_sig(1'b0, ERR_EN));
        end
        xact(1, 0, 32'h30, 32'h0);
        checks++;
        if (o_data !== (ERR_EN ? 32'h11 : 32'h55)) begin
            errors++;
            $display("FAIL rdwr_data: got %h want %h", o_data, ERR_EN ? 32'h11 : 32'h55);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) xact(0, 1, 32'((200 + i) << 2), $urandom);
        for (int i = 0; i < 40; i++) begin
            int op, ix;
            logic [31:0] a;
            op = $urandom_range(0, 3);
            ix = 200 + $urandom_range(0, 7);
            a = 32'(ix << 2);
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
            if ($urandom_range(0, 3) == 0) a[15:12] = 4'($urandom_range(1, 15));
            xact(op != 0, op == 0 || op == 3, a, $urandom);
            checks++;
            if (obs_sig() !== exp_sig(e_v, e_e)) begin
                errors++;
                $display("FAIL rand_timing[%0d]: addr=%h got %h want %h", i, a, obs_sig(), exp_sig(e_v, e_e));
            end
            if (e_v) begin
                checks++;
                if (o_data !== e_d) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: addr=%h got %h want %h", i, a, o_data, e_d);
                end
            end
            checks++;
            if (o_hold !== last_rd) begin
                errors++;
                $display("FAIL rand_hold[%0d]: got %h want %h", i, o_hold, last_rd);
            end
        end
    endtask

    task automatic test_back_to_back;
        int t[$];
        logic [31:0] bad;
        bad = 32'h0;
        @(negedge clk);
        bus1.wr = 1'b1; bus1.addr = 32'h8; bus1.wr_data = 32'h0BB0_0008;
        @(posedge clk);
        #1;
        bus1.wr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus1.rd = 1'b1;
        for (int c = 0; c < 13; c++) begin
            @(posedge clk);
            #1;
            if (bus1.rd_data_valid === 1'b1) begin
                t.push_back(c);
                if (bus1.rd_data !== 32'h0BB0_0008) bad = bus1.rd_data;
            end
        end
        bus1.rd = 1'b0;
        checks++;
        if (t.size() !== 4 || t[0] !== 1) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses first=%0d want 4 first=1", t.size(), t.size() > 0 ? t[0] : -1);
        end
        for (int i = 1; i < t.size(); i++) begin
            checks++;
            if (t[i] - t[i-1] !== 3) begin
                errors++;
                $display("FAIL b2b_spacing[%0d]: got %0d want 3", i, t[i] - t[i-1]);
            end
        end
        checks++;
        if (bad !== 32'h0) begin
            errors++;
            $display("FAIL b2b_data: got %h want 0bb00008", bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ignored();
        test_reset_abort();
        test_rd_wr_both();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
